// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide block and the ALU beside it.
package muldiv_pkg;

    // ALU opcodes; SUB/DEC report carry as "no borrow" (a >= b).
    localparam logic [3:0] ALU_NOT   = 4'd0;
    localparam logic [3:0] ALU_AND   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_XOR   = 4'd3;
    localparam logic [3:0] ALU_NAND  = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_XNOR  = 4'd6;
    localparam logic [3:0] ALU_SHL   = 4'd7;
    localparam logic [3:0] ALU_SHR   = 4'd8;
    localparam logic [3:0] ALU_ADD   = 4'd9;
    localparam logic [3:0] ALU_SUB   = 4'd10;
    localparam logic [3:0] ALU_INC   = 4'd11;
    localparam logic [3:0] ALU_DEC   = 4'd12;
    localparam logic [3:0] ALU_PASS  = 4'd13;
    localparam logic [3:0] ALU_PASSB = 4'd14;

    localparam int ITER_COUNT = 32;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A divide by zero skips the iteration loop entirely.
    function automatic logic isDivByZero(input op_t o, input logic [31:0] divisor);
        return (o == OP_DIV) && (divisor == 32'd0);
    endfunction

endpackage

// File: rtl/muldiv_alu.sv
// Combinational 32-bit ALU that the parent places beside muldiv_seq.
import muldiv_pkg::*;

module muldiv_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  opSel,
    output logic [31:0] result,
    output logic        carry
);

    // Opcode decode; carry is only meaningful for the arithmetic ops.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opSel)
            ALU_NOT:   result = ~a;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NAND:  result = ~(a & b);
            ALU_NOR:   result = ~(a | b);
            ALU_XNOR:  result = ~(a ^ b);
            ALU_SHL:   result = a << b[4:0];
            ALU_SHR:   result = a >> b[4:0];
            ALU_ADD:   {carry, result} = {1'b0, a} + {1'b0, b};
            ALU_SUB:   {carry, result} = {1'b0, a} + {1'b0, ~b} + 33'd1;
            ALU_INC:   {carry, result} = {1'b0, a} + 33'd1;
            ALU_DEC:   {carry, result} = {1'b0, a} + 33'h0_FFFF_FFFF;
            ALU_PASS:  result = a;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 unsigned multiply / 32/32 unsigned divide using an external ALU.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; results of the last op held on hi/lo
//   ST_ITER | one shift-add (MUL) or restoring-divide (DIV) step per cycle
//   ST_DONE | single cycle with done=1, results valid
import muldiv_pkg::*;

module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        divByZero,
    output logic [31:0] aluA,
    output logic [31:0] aluB,
    output logic [3:0]  aluOpSel,
    input  logic [31:0] aluResult,
    input  logic        aluCarry
);

    state_t      state, stateNext;
    logic [4:0]  iterCnt, iterCntNext;
    op_t         opReg, opNext;
    logic [31:0] mdReg, mdNext;     // multiplicand (MUL) or divisor (DIV)
    logic [31:0] hiReg, hiNext;
    logic [31:0] loReg, loNext;
    logic        dbzReg, dbzNext;
    logic [31:0] divShift;
    logic        divMsb;
    op_t         opIn;

    assign opIn      = op_t'(op);
    assign hi        = hiReg;
    assign lo        = loReg;
    assign divByZero = dbzReg;

    // State and datapath registers; reset clears everything, aborting any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            iterCnt <= '0;
            opReg   <= OP_MUL;
            mdReg   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            dbzReg  <= 1'b0;
        end else begin
            state   <= stateNext;
            iterCnt <= iterCntNext;
            opReg   <= opNext;
            mdReg   <= mdNext;
            hiReg   <= hiNext;
            loReg   <= loNext;
            dbzReg  <= dbzNext;
        end
    end

    // Next-state, iteration step and ALU drive.
    always_comb begin
        stateNext   = state;
        iterCntNext = iterCnt;
        opNext      = opReg;
        mdNext      = mdReg;
        hiNext      = hiReg;
        loNext      = loReg;
        dbzNext     = dbzReg;
        aluA        = '0;
        aluB        = '0;
        aluOpSel    = ALU_PASS;
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        // Partial remainder shifted left by one; its dropped msb forces a subtract.
        divShift    = {hiReg[30:0], loReg[31]};
        divMsb      = hiReg[31];

        case (state)
            ST_IDLE: begin
                if (start) begin
                    opNext      = opIn;
                    iterCntNext = '0;
                    mdNext      = (opIn == OP_DIV) ? opB : opA;
                    if (isDivByZero(opIn, opB)) begin
                        hiNext    = opA;
                        loNext    = '1;
                        dbzNext   = 1'b1;
                        stateNext = ST_DONE;
                    end else begin
                        hiNext    = '0;
                        loNext    = (opIn == OP_DIV) ? opA : opB;
                        dbzNext   = 1'b0;
                        stateNext = ST_ITER;
                    end
                end
            end

            ST_ITER: begin
                iterCntNext = iterCnt + 5'd1;
                if (iterCnt == 5'(ITER_COUNT - 1)) begin
                    stateNext = ST_DONE;
                end
                if (opReg == OP_MUL) begin
                    aluA     = hiReg;
                    aluB     = mdReg;
                    aluOpSel = ALU_ADD;
                    if (loReg[0]) begin
                        {hiNext, loNext} = {aluCarry, aluResult, loReg[31:1]};
                    end else begin
                        {hiNext, loNext} = {1'b0, hiReg, loReg[31:1]};
                    end
                end else begin
                    aluA     = divShift;
                    aluB     = mdReg;
                    aluOpSel = ALU_SUB;
                    if (divMsb || aluCarry) begin
                        hiNext = aluResult;
                        loNext = {loReg[30:0], 1'b1};
                    end else begin
                        hiNext = divShift;
                        loNext = {loReg[30:0], 1'b0};
                    end
                end
            end

            ST_DONE: stateNext = ST_IDLE;

            default: stateNext = ST_IDLE;
        endcase
    end

endmodule
